// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction ROM port, redirect request and the
// decoupled instruction output stream. The fetch unit takes the master
// view and its environment (ROM, branch unit, decoder) takes the slave view.
interface instr_fetch_if;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redir_valid,
    input  redir_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redir_valid,
    output redir_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_fault
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, combinational ROM lookup and a 2-entry
// {pc, instr} queue feeding the decoder. A redirect flushes the queue and
// restarts fetch from the target on the following cycle.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target parks the unit in a sticky FAULT state that presents a single
// faulting entry until the next redirect or reset. Without it the low two
// target bits are dropped.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t [1:0] fifo;
  entry_t       head;
  logic [31:0]  pc;
  logic [31:0]  pc_off;
  logic [31:0]  redir_tgt;
  logic [31:0]  fault_pc;
  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         fetch_en;
  logic         in_fault;
  logic         pop;
  logic         push;
  logic         unused_bits;

  // ROM index is the word offset from the text base; upper bits wrap
  assign pc_off        = pc - TEXT_BASE;
  assign bus.imem_addr = pc_off[12:2];

  assign head = fifo[rd_ptr];

  // a redirect flushes the queue, so any handshake in that cycle is void
  assign pop  = (count != 2'd0) && bus.out_ready && !bus.redir_valid;
  assign push = fetch_en && !bus.redir_valid && (!count[1] || pop);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {S_RUN, S_FAULT} state_t;
  state_t state, state_nxt;

  // fault state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // only a redirect moves between RUN and FAULT; its alignment picks which
  always_comb begin
    state_nxt = state;
    if (bus.redir_valid)
      state_nxt = (bus.redir_pc[1:0] != 2'b00) ? S_FAULT : S_RUN;
  end

  // remember the latest redirect target; it is only shown while in FAULT
  always_ff @(posedge clk) begin
    if (rst)                  fault_pc <= '0;
    else if (bus.redir_valid) fault_pc <= bus.redir_pc;
  end

  assign in_fault    = (state == S_FAULT);
  assign fetch_en    = !in_fault;
  assign redir_tgt   = bus.redir_pc;
  assign unused_bits = ^{pc_off[31:13], pc_off[1:0]};
`else
  assign in_fault    = 1'b0;
  assign fetch_en    = 1'b1;
  assign fault_pc    = '0;
  assign redir_tgt   = {bus.redir_pc[31:2], 2'b00};
  assign unused_bits = ^{pc_off[31:13], pc_off[1:0], bus.redir_pc[1:0]};
`endif

  // PC, queue pointers and occupancy; reset beats redirect beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (bus.redir_valid) begin
      pc     <= redir_tgt;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
    end
  end

  // queue storage; contents are don't-care until count says otherwise
  always_ff @(posedge clk) begin
    if (!rst && push)
      fifo[wr_ptr] <= {pc, bus.imem_data};
  end

  assign bus.out_valid = in_fault || (count != 2'd0);
  assign bus.out_fault = in_fault;
  assign bus.out_pc    = in_fault ? fault_pc : head.pc;
  assign bus.out_instr = in_fault ? 32'd0    : head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM word k holds value k. Stimulus queues the
// expected {pc, instr, fault} of every entry the consumer will accept;
// a monitor pops and compares on each accepted handshake.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (32'h0040_0000),
    .TEXT_BASE (32'h0040_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM: word k = k
  assign bus.imem_data = {21'd0, bus.imem_addr};

  // accepted-handshake monitor; reset and redirect cycles discard the pop
  always @(negedge clk) begin
    if (!rst && !bus.redir_valid && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h instr=%h fault=%b, required no output",
                 bus.out_pc, bus.out_instr, bus.out_fault);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr || bus.out_fault !== e.fault) begin
          errors++;
          $display("FAIL sb_entry got pc=%h instr=%h fault=%b, required pc=%h instr=%h fault=%b",
                   bus.out_pc, bus.out_instr, bus.out_fault, e.pc, e.instr, e.fault);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.fault = fault;
    sb.push_back(e);
  endtask

  // redirect with out_ready held high, then accept n entries and stall
  task automatic redirect_run(input logic [31:0] tgt, input int n);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = tgt;
    bus.out_ready   = 1'b1;
    step(1);
    bus.redir_valid = 1'b0;
    chk("flush_empty", {31'd0, bus.out_valid}, 32'd0);
    step(1 + n);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;
    bus.out_ready   = 1'b0;
    step(2);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_fault", {31'd0, bus.out_fault}, 32'd0);
    chk("rst_imem_addr", {21'd0, bus.imem_addr}, 32'd0);

    // stall from reset: queue fills to 2, pc parks at 0x00400008
    rst = 1'b0;
    step(1);
    chk("first_push_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("first_push_pc", bus.out_pc, 32'h0040_0000);
    step(4);
    chk("stall_imem_addr", {21'd0, bus.imem_addr}, 32'd2);
    chk("stall_head_pc", bus.out_pc, 32'h0040_0000);
    chk("stall_head_instr", bus.out_instr, 32'd0);

    // release: one instruction per cycle, in order, no bubble
    for (int k = 0; k < 6; k++)
      expect_entry(32'h0040_0000 + 32'(4 * k), 32'(k), 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("stream_no_gap", {31'd0, bus.out_valid}, 32'd1);
      step(1);
    end
    bus.out_ready = 1'b0;

    // redirect with a full queue and a ready consumer
    expect_entry(32'h0040_0100, 32'd64, 1'b0);
    expect_entry(32'h0040_0104, 32'd65, 1'b0);
    redirect_run(32'h0040_0100, 2);
    step(2);
    chk("refill_head_pc", bus.out_pc, 32'h0040_0108);

    // reset beats a simultaneous redirect and pop with a full queue
    rst             = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0040_0300;
    bus.out_ready   = 1'b1;
    step(1);
    chk("rst_ovr_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_ovr_imem_addr", {21'd0, bus.imem_addr}, 32'd0);
    chk("rst_ovr_fault", {31'd0, bus.out_fault}, 32'd0);
    rst             = 1'b0;
    bus.redir_valid = 1'b0;
    expect_entry(32'h0040_0000, 32'd0, 1'b0);
    expect_entry(32'h0040_0004, 32'd1, 1'b0);
    step(3);
    bus.out_ready = 1'b0;

`ifdef FETCH_MISALIGN_TRAP_EN
    // misaligned redirect: sticky fault entry across pops
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0040_0102;
    bus.out_ready   = 1'b1;
    step(1);
    bus.redir_valid = 1'b0;
    chk("fault_flag", {31'd0, bus.out_fault}, 32'd1);
    for (int k = 0; k < 3; k++)
      expect_entry(32'h0040_0102, 32'd0, 1'b1);
    step(3);
    chk("fault_sticky", {31'd0, bus.out_fault}, 32'd1);
    expect_entry(32'h0040_0200, 32'd128, 1'b0);
    redirect_run(32'h0040_0200, 1);
    chk("fault_cleared", {31'd0, bus.out_fault}, 32'd0);
`else
    // low target bits dropped: fetch from 0x00400100
    expect_entry(32'h0040_0100, 32'd64, 1'b0);
    expect_entry(32'h0040_0104, 32'd65, 1'b0);
    redirect_run(32'h0040_0102, 2);
    chk("no_fault", {31'd0, bus.out_fault}, 32'd0);
`endif

    // pc wraps at 2^32 and ROM index wraps at 2048 words
    expect_entry(32'hFFFF_FFFC, 32'd2047, 1'b0);
    expect_entry(32'h0000_0000, 32'd0, 1'b0);
    expect_entry(32'h0000_0004, 32'd1, 1'b0);
    redirect_run(32'hFFFF_FFFC, 3);

    step(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
